// File: rtl/det_nxn_bareiss_pkg.sv
`default_nettype none
// ============================================================================
// Package     : det_pkg
// Description : Shared FSM encoding, element index helper, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package det_pkg;

    localparam int DET_N_DEF      = 5;
    localparam int DET_DATA_W_DEF = 8;
    localparam int DET_ACC_W_DEF  = 48;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PIVOT  = 3'd2,
        MUL_A  = 3'd3,
        MUL_B  = 3'd4,
        DIV    = 3'd5,
        NEXT   = 3'd6,
        FINISH = 3'd7
    } det_state_t;

    // Row-major position of element (r,c) in an n x n matrix
    function automatic int DET_ELEM_IDX(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/det_nxn_bareiss_if.sv
`default_nettype none
// ============================================================================
// Interface   : det_nxn_bareiss_if
// Description : Request/result bundle of the determinant engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface det_nxn_bareiss_if
    import det_pkg::*;
#(
    parameter int N      = DET_N_DEF,
    parameter int DATA_W = DET_DATA_W_DEF,
    parameter int ACC_W  = DET_ACC_W_DEF
);
    logic                    start;
    logic [N*N*DATA_W-1:0]   A_flat;
    logic                    busy;
    logic                    done;
    logic [DATA_W-1:0]       det;
    logic [ACC_W-1:0]        det_full;
    logic                    overflow_flag;
    logic                    singular;

    modport master (
        output start, A_flat,
        input  busy, done, det, det_full, overflow_flag, singular
    );

    modport slave (
        input  start, A_flat,
        output busy, done, det, det_full, overflow_flag, singular
    );
endinterface
`default_nettype wire

// File: rtl/det_nxn_bareiss_sdiv.sv
`default_nettype none
// ============================================================================
// Module      : det_sdiv
// Description : Restoring signed divider, 2*ACC_W / ACC_W, fixed 2*ACC_W+1 latency.
// Revision    : 1.0 - initial release
// ============================================================================
module det_sdiv
    import det_pkg::*;
#(
    parameter int ACC_W = DET_ACC_W_DEF
) (
    input  wire logic                      clock,
    input  wire logic                      reset,
    input  wire logic                      i_start,
    input  wire logic signed [2*ACC_W-1:0] i_dividend,
    input  wire logic signed [ACC_W-1:0]   i_divisor,
    output logic                           o_done,
    output logic signed [ACC_W-1:0]        o_quotient
);
    localparam int DW = 2 * ACC_W;
    localparam int CW = $clog2(DW + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_q;
    logic [ACC_W-1:0] r_rem;
    logic [ACC_W-1:0] r_den;
    logic          r_neg;
    logic          r_done;
    logic signed [ACC_W-1:0] r_quot;

    logic [DW-1:0]    w_n_abs;
    logic [ACC_W-1:0] w_d_abs;
    logic [ACC_W:0]   w_sh;
    logic [ACC_W:0]   w_diff;
    logic             w_ge;

    // Magnitudes are unsigned, so the most negative operand still fits
    assign w_n_abs = i_dividend[DW-1]   ? DW'(-i_dividend)   : DW'(i_dividend);
    assign w_d_abs = i_divisor[ACC_W-1] ? ACC_W'(-i_divisor) : ACC_W'(i_divisor);
    assign w_sh    = {r_rem, r_q[DW-1]};
    assign w_diff  = w_sh - {1'b0, r_den};
    assign w_ge    = ~w_diff[ACC_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
            r_quot <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_q    <= w_n_abs;
                r_rem  <= '0;
                r_den  <= w_d_abs;
                r_neg  <= i_dividend[DW-1] ^ i_divisor[ACC_W-1];
            end else if (r_busy) begin
                if (r_cnt == CW'(DW)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_quot <= r_neg ? -$signed(r_q[ACC_W-1:0]) : $signed(r_q[ACC_W-1:0]);
                end else begin
                    r_q   <= {r_q[DW-2:0], w_ge};
                    r_rem <= w_ge ? w_diff[ACC_W-1:0] : w_sh[ACC_W-1:0];
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quot;
endmodule
`default_nettype wire

// File: rtl/det_nxn_bareiss.sv
`default_nettype none
// ============================================================================
// Module      : det_nxn_bareiss
// Description : Sequential N x N determinant via fraction-free Bareiss with
//               row pivoting. Define DET_SAT_EN to saturate det on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module det_nxn_bareiss
    import det_pkg::*;
#(
    parameter int N      = DET_N_DEF,
    parameter int DATA_W = DET_DATA_W_DEF,
    parameter int ACC_W  = DET_ACC_W_DEF
) (
    input  wire logic         clock,
    input  wire logic         reset,
    det_nxn_bareiss_if.slave  bus
);
    localparam int NN   = N * N;
    localparam int IDXW = $clog2(NN);
    localparam int KW   = $clog2(N + 1);
    localparam int PW   = 2 * ACC_W;
    localparam logic signed [ACC_W-1:0] c_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] r_m [NN];
    det_state_t              r_state;
    logic [KW-1:0]           r_k, r_i, r_j, r_scan;
    logic signed [ACC_W-1:0] r_prev;
    logic signed [PW-1:0]    r_p;
    logic                    r_neg_sign, r_zero, r_div_start;
    logic                    r_busy, r_done, r_ovf, r_sing;
    logic [DATA_W-1:0]       r_det;
    logic signed [ACC_W-1:0] r_det_full;

    logic [IDXW-1:0]         w_kk, w_ij, w_ik, w_kj, w_sk;
    logic signed [ACC_W-1:0] w_op_a, w_op_b, w_final, w_quot;
    logic signed [PW-1:0]    w_prod, w_p_next;
    logic                    w_ovf, w_div_done, w_adv_end;
    logic [DATA_W-1:0]       w_det;
    logic [KW-1:0]           w_nx_i, w_nx_j;

    assign w_kk = IDXW'(DET_ELEM_IDX(int'(r_k),    int'(r_k), N));
    assign w_ij = IDXW'(DET_ELEM_IDX(int'(r_i),    int'(r_j), N));
    assign w_ik = IDXW'(DET_ELEM_IDX(int'(r_i),    int'(r_k), N));
    assign w_kj = IDXW'(DET_ELEM_IDX(int'(r_k),    int'(r_j), N));
    assign w_sk = IDXW'(DET_ELEM_IDX(int'(r_scan), int'(r_k), N));

    // Single shared multiplier: MUL_A forms M[i][j]*M[k][k], MUL_B M[i][k]*M[k][j]
    assign w_op_a   = (r_state == MUL_A) ? r_m[w_ij] : r_m[w_ik];
    assign w_op_b   = (r_state == MUL_A) ? r_m[w_kk] : r_m[w_kj];
    assign w_prod   = PW'(w_op_a) * PW'(w_op_b);
    assign w_p_next = r_p - w_prod;

    always_comb begin
        w_nx_i    = r_i;
        w_nx_j    = r_j + KW'(1);
        w_adv_end = 1'b0;
        if (r_j == KW'(N - 1)) begin
            w_nx_i = r_i + KW'(1);
            w_nx_j = r_k + KW'(1);
            w_adv_end = (r_i == KW'(N - 1));
        end
    end

    assign w_final = r_zero ? '0 : (r_neg_sign ? -r_m[NN-1] : r_m[NN-1]);
    assign w_ovf   = (w_final > c_MAX) || (w_final < c_MIN);
`ifdef DET_SAT_EN
    assign w_det = w_ovf ? (w_final[ACC_W-1] ? c_MIN[DATA_W-1:0] : c_MAX[DATA_W-1:0])
                         : w_final[DATA_W-1:0];
`else
    assign w_det = w_final[DATA_W-1:0];
`endif

    det_sdiv #(.ACC_W(ACC_W)) u_div (
        .clock      (clock),
        .reset      (reset),
        .i_start    (r_div_start),
        .i_dividend (r_p),
        .i_divisor  (r_prev),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_det       <= '0;
            r_det_full  <= '0;
            r_ovf       <= 1'b0;
            r_sing      <= 1'b0;
            r_div_start <= 1'b0;
            r_k         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_scan      <= '0;
            r_prev      <= '0;
            r_p         <= '0;
            r_neg_sign  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_div_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        for (int e = 0; e < NN; e++)
                            r_m[e] <= ACC_W'($signed(bus.A_flat[e*DATA_W +: DATA_W]));
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                LOAD: begin
                    r_k        <= '0;
                    r_prev     <= ACC_W'(1);
                    r_neg_sign <= 1'b0;
                    r_zero     <= 1'b0;
                    r_scan     <= KW'(1);
                    r_state    <= PIVOT;
                end
                PIVOT: begin
                    if (r_m[w_kk] != '0) begin
                        r_i     <= r_k + KW'(1);
                        r_j     <= r_k + KW'(1);
                        r_state <= MUL_A;
                    end else if (r_scan == KW'(N)) begin
                        r_zero  <= 1'b1;
                        r_state <= FINISH;
                    end else if (r_m[w_sk] != '0) begin
                        for (int c = 0; c < N; c++) begin
                            r_m[IDXW'(DET_ELEM_IDX(int'(r_k), c, N))]    <= r_m[IDXW'(DET_ELEM_IDX(int'(r_scan), c, N))];
                            r_m[IDXW'(DET_ELEM_IDX(int'(r_scan), c, N))] <= r_m[IDXW'(DET_ELEM_IDX(int'(r_k), c, N))];
                        end
                        r_neg_sign <= ~r_neg_sign;
                    end else begin
                        r_scan <= r_scan + KW'(1);
                    end
                end
                MUL_A: begin
                    r_p     <= w_prod;
                    r_state <= MUL_B;
                end
                MUL_B: begin
                    // First pass divides by 1, so the divider is bypassed
                    if (r_k == '0) begin
                        r_m[w_ij] <= w_p_next[ACC_W-1:0];
                        r_i       <= w_nx_i;
                        r_j       <= w_nx_j;
                        r_state   <= w_adv_end ? NEXT : MUL_A;
                    end else begin
                        r_p         <= w_p_next;
                        r_div_start <= 1'b1;
                        r_state     <= DIV;
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_m[w_ij] <= w_quot;
                        r_i       <= w_nx_i;
                        r_j       <= w_nx_j;
                        r_state   <= w_adv_end ? NEXT : MUL_A;
                    end
                end
                NEXT: begin
                    r_prev  <= r_m[w_kk];
                    r_k     <= r_k + KW'(1);
                    r_scan  <= r_k + KW'(2);
                    r_state <= (r_k + KW'(1) == KW'(N - 1)) ? FINISH : PIVOT;
                end
                FINISH: begin
                    r_det_full <= w_final;
                    r_det      <= w_det;
                    r_ovf      <= w_ovf;
                    r_sing     <= (w_final == '0);
                    r_done     <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.det           = r_det;
    assign bus.det_full      = r_det_full;
    assign bus.overflow_flag = r_ovf;
    assign bus.singular      = r_sing;
endmodule
`default_nettype wire

// File: tb/tb_det_nxn_bareiss.sv
`default_nettype none
// ============================================================================
// Module      : tb_det_nxn_bareiss
// Description : Self-checking bench for det_nxn_bareiss (N=5 and N=2 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_det_nxn_bareiss;
    import det_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 48;
    localparam int LIM5 = 125 * (2 * AW + 4) + 4 * 5 + 4;
    localparam int LIM2 = 8 * (2 * AW + 4) + 4 * 2 + 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    det_nxn_bareiss_if #(.N(5), .DATA_W(DW), .ACC_W(AW)) bus5 ();
    det_nxn_bareiss_if #(.N(2), .DATA_W(DW), .ACC_W(AW)) bus2 ();

    det_nxn_bareiss #(.N(5), .DATA_W(DW), .ACC_W(AW)) dut5 (.clock(clock), .reset(reset), .bus(bus5.slave));
    det_nxn_bareiss #(.N(2), .DATA_W(DW), .ACC_W(AW)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

    int     n_pass   = 0;
    int     n_fail   = 0;
    int     n_checks = 0;
    longint mat [36];
    longint prev5 = 0;
    longint prev2 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Leibniz sum over all permutations of column indices
    function automatic longint ref_det(input int n, input longint a [36]);
        longint sum;
        int     total;
        sum   = 0;
        total = 1;
        for (int i = 0; i < n; i++) total *= n;
        for (int t = 0; t < total; t++) begin
            int     p [6];
            int     v;
            int     inv;
            bit     ok;
            longint prod;
            v = t; inv = 0; ok = 1'b1; prod = 1;
            for (int r = 0; r < n; r++) begin p[r] = v % n; v = v / n; end
            for (int r = 0; r < n; r++)
                for (int s = r + 1; s < n; s++) begin
                    if (p[r] == p[s]) ok = 1'b0;
                    else if (p[r] > p[s]) inv++;
                end
            if (ok) begin
                for (int r = 0; r < n; r++) prod *= a[r*n + p[r]];
                sum += (inv % 2 == 1) ? -prod : prod;
            end
        end
        return sum;
    endfunction

    function automatic longint exp_det8(input longint f);
        logic [7:0] lo;
        lo = f[7:0];
`ifdef DET_SAT_EN
        if (f > 127)  return 127;
        if (f < -128) return -128;
`endif
        return longint'($signed(lo));
    endfunction

    function automatic logic exp_ovf(input longint f);
        return (f > 127) || (f < -128);
    endfunction

    task automatic set_diag(input int n, input longint d [6]);
        for (int i = 0; i < 36; i++) mat[i] = 0;
        for (int i = 0; i < n; i++) mat[i*n + i] = d[i];
    endtask

    task automatic set_rand(input int n);
        for (int i = 0; i < 36; i++) mat[i] = 0;
        for (int i = 0; i < n*n; i++) mat[i] = longint'($urandom_range(0, 255)) - 128;
    endtask

    task automatic run5(input string tag, input longint exp_full, input bit glitch);
        bit seen;
        for (int i = 0; i < 25; i++) bus5.A_flat[i*DW +: DW] = DW'(mat[i]);
        @(posedge clock); #1;
        bus5.start = 1'b1;
        @(posedge clock); #1;
        bus5.start = 1'b0;
        check({tag, "_busy_on"}, 64'(bus5.busy), 64'd1);
        check({tag, "_hold"}, 64'($signed(bus5.det_full)), 64'(prev5));
        seen = 1'b0;
        for (int c = 0; c < LIM5; c++) begin
            if (bus5.done) begin seen = 1'b1; break; end
            if (glitch && c == 6) begin
                for (int i = 0; i < 25; i++) bus5.A_flat[i*DW +: DW] = DW'($urandom);
                bus5.start = 1'b1;
            end
            if (glitch && c == 7) bus5.start = 1'b0;
            @(posedge clock); #1;
        end
        check({tag, "_done"},     64'(seen), 64'd1);
        check({tag, "_busy_done"}, 64'(bus5.busy), 64'd1);
        check({tag, "_det_full"}, 64'($signed(bus5.det_full)), 64'(exp_full));
        check({tag, "_det"},      64'($signed(bus5.det)), 64'(exp_det8(exp_full)));
        check({tag, "_ovf"},      64'(bus5.overflow_flag), 64'(exp_ovf(exp_full)));
        check({tag, "_sing"},     64'(bus5.singular), 64'(exp_full == 0));
        @(posedge clock); #1;
        check({tag, "_pulse"},    64'(bus5.done), 64'd0);
        check({tag, "_busy_off"}, 64'(bus5.busy), 64'd0);
        prev5 = exp_full;
    endtask

    task automatic run2(input string tag, input longint exp_full);
        bit seen;
        for (int i = 0; i < 4; i++) bus2.A_flat[i*DW +: DW] = DW'(mat[i]);
        @(posedge clock); #1;
        bus2.start = 1'b1;
        @(posedge clock); #1;
        bus2.start = 1'b0;
        check({tag, "_hold"}, 64'($signed(bus2.det_full)), 64'(prev2));
        seen = 1'b0;
        for (int c = 0; c < LIM2; c++) begin
            if (bus2.done) begin seen = 1'b1; break; end
            @(posedge clock); #1;
        end
        check({tag, "_done"},     64'(seen), 64'd1);
        check({tag, "_det_full"}, 64'($signed(bus2.det_full)), 64'(exp_full));
        check({tag, "_det"},      64'($signed(bus2.det)), 64'(exp_det8(exp_full)));
        check({tag, "_ovf"},      64'(bus2.overflow_flag), 64'(exp_ovf(exp_full)));
        check({tag, "_sing"},     64'(bus2.singular), 64'(exp_full == 0));
        @(posedge clock); #1;
        check({tag, "_pulse"},    64'(bus2.done), 64'd0);
        prev2 = exp_full;
    endtask

    task automatic check_zero5(input string tag);
        check({tag, "_busy"},     64'(bus5.busy), 64'd0);
        check({tag, "_done"},     64'(bus5.done), 64'd0);
        check({tag, "_det"},      64'(bus5.det), 64'd0);
        check({tag, "_det_full"}, 64'(bus5.det_full), 64'd0);
        check({tag, "_ovf"},      64'(bus5.overflow_flag), 64'd0);
        check({tag, "_sing"},     64'(bus5.singular), 64'd0);
    endtask

    initial begin
        longint d [6];
        bit     late_done;
        bus5.start = 1'b0; bus5.A_flat = '0;
        bus2.start = 1'b0; bus2.A_flat = '0;

        repeat (3) @(posedge clock);
        #1;
        check_zero5("reset");
        reset = 1'b0;

        d = '{1, 1, 1, 1, 1, 0};
        set_diag(5, d);
        run5("ident", 1, 1'b0);

        d = '{2, 3, 4, 5, 6, 0};
        set_diag(5, d);
        run5("diag720", 720, 1'b0);

        d = '{1, 1, 1, 1, 1, 0};
        set_diag(5, d);
        mat[0] = 0; mat[1] = 1; mat[5] = 1; mat[6] = 0;
        run5("swap01", -1, 1'b0);

        set_rand(5);
        for (int c = 0; c < 5; c++) mat[15 + c] = mat[5 + c];
        run5("dup_row", 0, 1'b0);

        set_rand(5);
        for (int r = 0; r < 5; r++) mat[r*5] = 0;
        run5("zero_col", 0, 1'b0);

        d = '{-128, -128, -128, -128, -128, 0};
        set_diag(5, d);
        run5("diag_m128", -64'sd34359738368, 1'b0);

        for (int t = 0; t < 4; t++) begin
            set_rand(5);
            if (t == 1) mat[0] = 0;
            if (t == 2) begin mat[0] = 0; mat[5] = 0; end
            run5($sformatf("rand5_%0d", t), ref_det(5, mat), 1'b0);
        end

        set_rand(5);
        run5("start_busy", ref_det(5, mat), 1'b1);

        mat[0] = 3; mat[1] = 4; mat[2] = 5; mat[3] = 6;
        run2("n2_fixed", -2);
        for (int t = 0; t < 3; t++) begin
            set_rand(2);
            run2($sformatf("rand2_%0d", t), ref_det(2, mat));
        end

        // Abort deep in the elimination, while the divider is iterating
        set_rand(5);
        for (int i = 0; i < 25; i++) bus5.A_flat[i*DW +: DW] = DW'(mat[i]);
        @(posedge clock); #1;
        bus5.start = 1'b1;
        @(posedge clock); #1;
        bus5.start = 1'b0;
        repeat (300) @(posedge clock);
        #1;
        check("abort_busy", 64'(bus5.busy), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_zero5("abort");
        late_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus5.done) late_done = 1'b1;
            @(posedge clock); #1;
        end
        check("abort_no_done", 64'(late_done), 64'd0);
        prev5 = 0;

        d = '{1, 1, 1, 1, 1, 0};
        set_diag(5, d);
        run5("ident_after", 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/det_nxn_bareiss.md
Name: det_nxn_bareiss

Overview:
- Sequential, parametrised determinant engine for square signed matrices of size N x N with element width DATA_W.
- Uses fraction-free Bareiss elimination with row pivoting, one shared multiplier and a multi-cycle exact signed divider.
- Replaces the fixed 5x5 combinational Laplace unit in the coprocessor's determinant path, adding a start/done handshake, a full-precision result and a singular flag.

Parameters:
- N, 5, matrix order; supported range 2..6.
- DATA_W, 8, element and truncated-result width (signed).
- ACC_W, 48, internal matrix-entry and full-result width (signed). Must be at least the Hadamard bound for N and DATA_W.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- A_flat  in  N*N*DATA_W  element (r,c) at [(r*N+c)*DATA_W +: DATA_W]; row 0 lowest
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse when the result is valid
- det  out  DATA_W  result truncated (or saturated, see Optional Feature) to DATA_W
- det_full  out  ACC_W  exact signed determinant
- overflow_flag  out  1  det_full lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1]
- singular  out  1  det_full == 0

Behaviour:
- Reset values: busy=0, done=0, det=0, det_full=0, overflow_flag=0, singular=0; FSM goes to IDLE.
- Reset mid-operation aborts immediately, with no done pulse.
- FSM states: IDLE, LOAD, PIVOT, MUL_A, MUL_B, DIV, NEXT, FINISH.
- IDLE:
  - start=1 captures A_flat, sign-extended into an internal N*N ACC_W array, then goes to LOAD.
  - start while not in IDLE is ignored.
- LOAD (1 cycle): k=0, prev=1, sign=+1.
- PIVOT:
  - If M[k][k]!=0, go to MUL_A.
  - Otherwise scan rows i>k in ascending order, one row per cycle. On the first M[i][k]!=0, swap rows k and i and negate sign.
  - If no such row exists: det_full=0, go to FINISH.
- Update of each (i,j) with i,j in k+1..N-1, row-major order:
  - MUL_A computes p = M[i][j]*M[k][k].
  - MUL_B computes p = p - M[i][k]*M[k][j]. p is 2*ACC_W wide.
  - DIV computes M[i][j] = p / prev via the divider sub-module. The division is exact (remainder always 0).
  - DIV is skipped when k==0 (prev=1); in that case p is truncated to ACC_W.
- NEXT: prev=M[k][k], k=k+1. If k==N-1 go to FINISH, else go to PIVOT.
- FINISH (1 cycle):
  - det_full = sign*M[N-1][N-1] unless already zeroed in PIVOT.
  - Assert done; register det, overflow_flag and singular; return to IDLE.
- Outputs hold until the next accepted start. They do not change during a computation.
- Truncation: det = det_full[DATA_W-1:0].
- Latency is data-dependent, bounded by N^3*(2*ACC_W+4) + 4*N + 4 cycles.

Optional Feature:
- Macro DET_SAT_EN.
- Defined: det saturates to 2^(DATA_W-1)-1 or -2^(DATA_W-1) when overflow_flag=1.
- Undefined: det is the two's-complement truncation.
- overflow_flag behaves identically in both builds.

Decomposition:
- Package det_pkg:
  - FSM state enum
  - DET_ELEM_IDX(r,c) index function
  - default width constants
- Sub-module det_sdiv:
  - Sequential restoring signed divider, 2*ACC_W-bit dividend, ACC_W-bit divisor.
  - start/done handshake, quotient truncated to ACC_W.
  - Fixed 2*ACC_W+1 cycle latency.

Test Plan:
- N=5 identity, start -> one done pulse; det_full=1, det=1, overflow_flag=0, singular=0; busy low after done.
- N=5 diag(2,3,4,5,6) -> det_full=720, det=0xD0 (-48), overflow_flag=1. With DET_SAT_EN: det=127.
- N=5 identity with rows 0 and 1 swapped (zero leading pivot) -> det_full=-1, det=0xFF, overflow_flag=0.
- N=5 with row 3 == row 1 -> det_full=0, singular=1, done asserted. Also all-zero column 0 -> early PIVOT exit, det_full=0.
- N=5 diag(-128 x5) -> det_full=-34359738368, det=0x00, overflow_flag=1. N=2 [[3,4],[5,6]] -> det_full=-2, det=0xFE.
- start pulsed while busy -> ignored; result unchanged. reset asserted mid-DIV -> next cycle all outputs 0, no done. A following start on the identity matrix computes correctly.
